tri_wave_checker: RTL and testbench

- Receive-side monitor for the gradual up/down counter stream: 0,1,…,PEAK,PEAK-1,…,0,1,… with no repeats at the turning points.
- Takes sampled count values with a valid qualifier, locks onto the triangle pattern, and tracks the expected next value and direction.
- Flags mismatches, reports peaks, troughs and completed periods.
- Sits at the far end of any link carrying the counter value; used for link checking and self-test.

---
 rtl/tri_wave_checker_pkg.sv | 28 ++
 rtl/tri_wave_checker_if.sv | 28 ++
 rtl/tri_wave_checker_sat_counter.sv | 22 ++
 rtl/tri_wave_checker.sv | 143 ++++++++++++++
 tb/tb_tri_wave_checker.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tri_wave_checker_pkg.sv
// Shared types, defaults and the triangle step rule for tri_wave_checker.
// Latency: none (types and functions only); no backpressure.
package tri_pkg;

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEF_WIDTH  = 3;
  localparam int DEF_PEAK   = 3;
  localparam int DEF_LOCK_N = 4;
  localparam int DEF_LOSS_N = 3;

  // next(v,d): value half of the step
  function automatic int next_val(input int v, input logic d);
    return (d == DIR_UP) ? v + 1 : v - 1;
  endfunction

  // next(v,d): direction half; turns exactly on reaching PEAK or 0
  function automatic logic next_dir(input int v, input logic d, input int peak);
    if (d == DIR_UP)
      return (v + 1 == peak) ? DIR_DOWN : DIR_UP;
    else
      return (v - 1 == 0) ? DIR_UP : DIR_DOWN;
  endfunction

endpackage

// File: rtl/tri_wave_checker_if.sv
// Sample stream plus status outputs of the triangle-wave checker.
// Latency: wires only; in_valid qualifies samples, no backpressure.
interface tri_wave_checker_if
  import tri_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] in_count;
  logic             clr_err;
  logic             locked;
  logic             dir;
  logic             err_pulse;
  logic [7:0]       err_cnt;
  logic             peak_pulse;
  logic             trough_pulse;
  logic [15:0]      period_cnt;

  modport master (
    output in_valid, in_count, clr_err,
    input  locked, dir, err_pulse, err_cnt, peak_pulse, trough_pulse, period_cnt
  );

  modport slave (
    input  in_valid, in_count, clr_err,
    output locked, dir, err_pulse, err_cnt, peak_pulse, trough_pulse, period_cnt
  );
endinterface

// File: rtl/tri_wave_checker_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
// Latency: 1 cycle from inc/clr to cnt; no backpressure.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/tri_wave_checker.sv
// Locks onto a 0..PEAK..0 triangle count stream, flags mismatches, reports turns.
// Latency: 1 cycle from sample edge to registered outputs; no backpressure.
module tri_wave_checker
  import tri_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PEAK   = DEF_PEAK,
  parameter int LOCK_N = DEF_LOCK_N,
  parameter int LOSS_N = DEF_LOSS_N
) (
  input logic              clk,
  input logic              rst,
  tri_wave_checker_if.slave tw
);

  localparam int AW = $clog2(LOCK_N + 1);
  localparam int MW = $clog2(LOSS_N + 1);
  localparam logic [WIDTH-1:0] PK = WIDTH'(PEAK);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             dir_q, dir_d;
  logic [AW-1:0]    acq_q, acq_d, acq_inc;
  logic [MW-1:0]    miss_q, miss_d, miss_inc;
  logic             err_q, err_d;
  logic             pk_q, pk_d;
  logic             tr_q, tr_d;

  logic             match, seed_zero, seed_hit, seed_din;
  int               seed_base;

  assign match     = (tw.in_count == exp_q);
  assign seed_zero = (tw.in_count == '0);
  assign seed_hit  = seed_zero || (tw.in_count == PK);
  assign seed_base = seed_zero ? 0 : PEAK;
  assign seed_din  = seed_zero ? DIR_UP : DIR_DOWN;
  assign acq_inc   = acq_q + 1'b1;
  assign miss_inc  = miss_q + 1'b1;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    dir_d   = dir_q;
    acq_d   = acq_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    pk_d    = 1'b0;
    tr_d    = 1'b0;
    if (tw.in_valid) begin
      case (state_q)
        HUNT: begin
          if (seed_hit) begin
            state_d = ACQ;
            exp_d   = WIDTH'(next_val(seed_base, seed_din));
            dir_d   = next_dir(seed_base, seed_din, PEAK);
            acq_d   = '0;
          end
        end
        ACQ: begin
          if (match) begin
            exp_d = WIDTH'(next_val(int'(exp_q), dir_q));
            dir_d = next_dir(int'(exp_q), dir_q, PEAK);
            acq_d = acq_inc;
            if (acq_inc == AW'(LOCK_N)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            // A broken acquisition may still be a fresh seed
            state_d = HUNT;
            if (seed_hit) begin
              state_d = ACQ;
              exp_d   = WIDTH'(next_val(seed_base, seed_din));
              dir_d   = next_dir(seed_base, seed_din, PEAK);
              acq_d   = '0;
            end
          end
        end
        LOCKED: begin
          // Flywheel: advance from the expected value whether or not it matched
          exp_d = WIDTH'(next_val(int'(exp_q), dir_q));
          dir_d = next_dir(int'(exp_q), dir_q, PEAK);
          if (match) begin
            miss_d = '0;
            pk_d   = (tw.in_count == PK);
            tr_d   = seed_zero;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (miss_inc == MW'(LOSS_N))
              state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      exp_q   <= '0;
      dir_q   <= DIR_UP;
      acq_q   <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      pk_q    <= 1'b0;
      tr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      dir_q   <= dir_d;
      acq_q   <= acq_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      pk_q    <= pk_d;
      tr_q    <= tr_d;
    end
  end

  sat_counter #(.W(8)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_d),
    .clr (tw.clr_err),
    .cnt (tw.err_cnt)
  );

  sat_counter #(.W(16)) u_period_cnt (
    .clk (clk),
    .rst (rst),
    .inc (tr_d),
    .clr (tw.clr_err),
    .cnt (tw.period_cnt)
  );

  assign tw.locked       = (state_q == LOCKED);
  assign tw.dir          = dir_q;
  assign tw.err_pulse    = err_q;
  assign tw.peak_pulse   = pk_q;
  assign tw.trough_pulse = tr_q;

endmodule

// File: tb/tb_tri_wave_checker.sv
// Scoreboard bench: each driven cycle pushes the model's expected outputs; a monitor pops and compares.
module tb_tri_wave_checker;

  localparam int W  = 3;
  localparam int P  = 3;
  localparam int LN = 4;
  localparam int LS = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tri_wave_checker_if #(.WIDTH(W)) tw ();

  tri_wave_checker #(.WIDTH(W), .PEAK(P), .LOCK_N(LN), .LOSS_N(LS)) dut (
    .clk (clk),
    .rst (rst),
    .tw  (tw)
  );

  typedef struct packed {
    logic        locked;
    logic        dir;
    logic        errp;
    logic        pk;
    logic        tr;
    logic [7:0]  ec;
    logic [15:0] pc;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e, mon_a;
  int errors = 0;
  int checks = 0;

  // Model: position within the period (0..2P-1) instead of value+direction
  int m_st, m_ph, m_acq, m_miss, m_ec, m_pc;
  int gp;

  function automatic int wave(input int ph);
    return (ph <= P) ? ph : 2 * P - ph;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ph = 0; m_acq = 0; m_miss = 0; m_ec = 0; m_pc = 0;
  endtask

  task automatic model_seed(input int c);
    if (c == 0) begin
      m_st = 1; m_ph = 1; m_acq = 0;
    end else if (c == P) begin
      m_st = 1; m_ph = P + 1; m_acq = 0;
    end else begin
      m_st = 0;
    end
  endtask

  task automatic send(input bit v, input int c, input bit clr);
    resp_t r;
    @(negedge clk);
    tw.in_valid = v;
    tw.in_count = W'(c);
    tw.clr_err  = clr;
    r = '0;
    if (v) begin
      case (m_st)
        0: model_seed(c);
        1: begin
          if (c == wave(m_ph)) begin
            m_ph = (m_ph + 1) % (2 * P);
            m_acq++;
            if (m_acq == LN) begin m_st = 2; m_miss = 0; end
          end else begin
            model_seed(c);
          end
        end
        default: begin
          if (c == wave(m_ph)) begin
            m_miss = 0;
            r.pk = (c == P);
            r.tr = (c == 0);
          end else begin
            r.errp = 1'b1;
            m_miss++;
            if (m_ec < 255) m_ec++;
            if (m_miss == LS) m_st = 0;
          end
          m_ph = (m_ph + 1) % (2 * P);
        end
      endcase
    end
    if (r.tr && m_pc < 65535) m_pc++;
    if (clr) begin m_ec = 0; m_pc = 0; end
    r.locked = (m_st == 2);
    r.dir    = (m_ph >= P);
    r.ec     = m_ec[7:0];
    r.pc     = m_pc[15:0];
    exp_q.push_back(r);
  endtask

  task automatic clean(input int n, input bit bub);
    repeat (n) begin
      send(1'b1, wave(gp), 1'b0);
      gp = (gp + 1) % (2 * P);
      if (bub) send(1'b0, $urandom_range(0, 7), 1'b0);
    end
  endtask

  task automatic bad(input bit clr);
    send(1'b1, (wave(gp) + 4) % 8, clr);
    gp = (gp + 1) % (2 * P);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Outputs as seen just after the edge that sampled the last send
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic zero_check(input string name);
    check({name, "_locked"}, int'(tw.locked), 0);
    check({name, "_dir"}, int'(tw.dir), 0);
    check({name, "_pulses"}, int'({tw.err_pulse, tw.peak_pulse, tw.trough_pulse}), 0);
    check({name, "_err_cnt"}, int'(tw.err_cnt), 0);
    check({name, "_period_cnt"}, int'(tw.period_cnt), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tw.in_valid = 1'b0;
    tw.clr_err  = 1'b0;
    #1;
    zero_check("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {tw.locked, tw.dir, tw.err_pulse, tw.peak_pulse, tw.trough_pulse,
                 tw.err_cnt, tw.period_cnt};
        checks++;
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL resp t=%0t got lk=%0b dir=%0b err=%0b pk=%0b tr=%0b ec=%0d pc=%0d expected lk=%0b dir=%0b err=%0b pk=%0b tr=%0b ec=%0d pc=%0d",
                   $time, mon_a.locked, mon_a.dir, mon_a.errp, mon_a.pk, mon_a.tr, mon_a.ec, mon_a.pc,
                   mon_e.locked, mon_e.dir, mon_e.errp, mon_e.pk, mon_e.tr, mon_e.ec, mon_e.pc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    rst = 1'b1;
    tw.in_valid = 1'b0;
    tw.in_count = '0;
    tw.clr_err  = 1'b0;
    model_reset();
    #1;
    zero_check("power_on");
    @(negedge clk);
    rst = 1'b0;

    // Clean stream from HUNT: 2,1 ignored, 0 seeds, lock after second 2
    gp = 4;
    clean(9, 1'b0);
    settle();
    check("clean_locked", int'(tw.locked), 1);
    check("clean_period", int'(tw.period_cnt), 1);

    // Single glitch while locked
    clean(2, 1'b0);
    bad(1'b0);
    clean(3, 1'b0);
    settle();
    check("glitch_err_cnt", int'(tw.err_cnt), 1);
    check("glitch_locked", int'(tw.locked), 1);

    // Three consecutive mismatches drop lock, then a 0 reseeds
    repeat (3) begin
      send(1'b1, 5, 1'b0);
      gp = (gp + 1) % (2 * P);
    end
    settle();
    check("loss_locked", int'(tw.locked), 0);
    check("loss_err_cnt", int'(tw.err_cnt), 4);
    gp = 0;
    clean(12, 1'b0);

    // Reset mid-lock
    check("pre_reset_locked", int'(tw.locked), 1);
    do_reset();

    // Bubbles between every valid sample
    gp = 0;
    clean(14, 1'b1);
    settle();
    check("bubble_locked", int'(tw.locked), 1);
    check("bubble_period", int'(tw.period_cnt), 2);

    // Clear colliding with a locked mismatch
    bad(1'b0);
    bad(1'b1);
    settle();
    check("clr_err_pulse", int'(tw.err_pulse), 1);
    check("clr_err_cnt", int'(tw.err_cnt), 0);

    // Drive err_cnt into saturation while holding lock
    clean(1, 1'b0);
    repeat (260) begin
      bad(1'b0);
      clean(1, 1'b0);
    end
    settle();
    check("sat_err_cnt", int'(tw.err_cnt), 255);
    check("sat_locked", int'(tw.locked), 1);

    // Randomized traffic around a free-running wave
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (i == 1500) do_reset();
      if (r < 8) begin
        send(1'b0, $urandom_range(0, 7), ($urandom_range(0, 49) == 0));
      end else if (r < 20) begin
        send(1'b1, $urandom_range(0, 7), ($urandom_range(0, 49) == 0));
        gp = (gp + 1) % (2 * P);
      end else begin
        send(1'b1, wave(gp), ($urandom_range(0, 49) == 0));
        gp = (gp + 1) % (2 * P);
      end
    end

    settle();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
